// File: rtl/ndma_xfer_ctrl_if.sv
// Read/write manager bus of the DMA transfer controller.
// The master modport is the controller side; the slave modport is the manager side.
interface ndma_xfer_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              rd_req_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic              rd_busy_i;
    logic              rd_rvalid_i;
    logic [DATA_W-1:0] rd_rdata_i;
    logic              wr_req_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [DATA_W-1:0] wr_wdata_o;
    logic              wr_busy_i;
    logic              wr_done_i;

    modport master (
        output rd_req_o, rd_addr_o, wr_req_o, wr_addr_o, wr_wdata_o,
        input  rd_busy_i, rd_rvalid_i, rd_rdata_i, wr_busy_i, wr_done_i
    );

    modport slave (
        input  rd_req_o, rd_addr_o, wr_req_o, wr_addr_o, wr_wdata_o,
        output rd_busy_i, rd_rvalid_i, rd_rdata_i, wr_busy_i, wr_done_i
    );
endinterface

// File: rtl/ndma_xfer_ctrl.sv
// Memory-to-memory DMA sequencer: one word in flight, read then write, LEN times.
// Reports done/abort pulses and a sticky IRQ.
module ndma_xfer_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned STRIDE = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              src_inc_i,
    input  logic              dst_inc_i,
    input  logic              irq_clr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic              irq_o,
    output logic [LEN_W-1:0]  words_left_o,
    ndma_xfer_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_FINISH, S_ABORTED
    } state_e;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

    state_e            state_q;
    logic [ADDR_W-1:0] src_q, dst_q, src_d, dst_d;
    logic [LEN_W-1:0]  count_q;
    logic [DATA_W-1:0] wdata_q;
    logic              src_inc_q, dst_inc_q;
    logic              abort_q, abort_pend;
    logic              done_q, aborted_q, irq_q;

    // A pulse arriving in the same cycle as a decision point takes effect at once.
    always_comb begin
        abort_pend = abort_q | abort_i;
        src_d      = src_inc_q ? src_q + STEP : src_q;
        dst_d      = dst_inc_q ? dst_q + STEP : dst_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            count_q   <= '0;
            wdata_q   <= '0;
            src_inc_q <= 1'b0;
            dst_inc_q <= 1'b0;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            irq_q     <= irq_q & ~irq_clr_i;
            abort_q   <= (state_q == S_IDLE) ? 1'b0 : abort_pend;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        src_q     <= src_addr_i;
                        dst_q     <= dst_addr_i;
                        count_q   <= len_i;
                        src_inc_q <= src_inc_i;
                        dst_inc_q <= dst_inc_i;
                        if (len_i == '0) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                            irq_q   <= 1'b1;
                        end else begin
                            state_q <= S_RD_REQ;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (abort_pend) begin
                        state_q   <= S_ABORTED;
                        aborted_q <= 1'b1;
                        irq_q     <= 1'b1;
                    end else if (!bus.rd_busy_i) begin
                        state_q <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (bus.rd_rvalid_i) begin
                        wdata_q <= bus.rd_rdata_i;
                        if (abort_pend) begin
                            state_q   <= S_ABORTED;
                            aborted_q <= 1'b1;
                            irq_q     <= 1'b1;
                        end else begin
                            state_q <= S_WR_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (abort_pend) begin
                        state_q   <= S_ABORTED;
                        aborted_q <= 1'b1;
                        irq_q     <= 1'b1;
                    end else if (!bus.wr_busy_i) begin
                        state_q <= S_WR_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (bus.wr_done_i) begin
                        count_q <= count_q - LEN_W'(1);
                        src_q   <= src_d;
                        dst_q   <= dst_d;
                        // Completing the last word reports done even if an abort is pending.
                        if (count_q == LEN_W'(1)) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                            irq_q   <= 1'b1;
                        end else if (abort_pend) begin
                            state_q   <= S_ABORTED;
                            aborted_q <= 1'b1;
                            irq_q     <= 1'b1;
                        end else begin
                            state_q <= S_RD_REQ;
                        end
                    end
                end
                S_FINISH, S_ABORTED: state_q <= S_IDLE;
                default:             state_q <= S_IDLE;
            endcase
        end
    end

    // Strobes are gated by the live busy inputs so none is ever issued into a busy manager.
    assign bus.rd_req_o   = (state_q == S_RD_REQ) && !bus.rd_busy_i && !abort_pend;
    assign bus.wr_req_o   = (state_q == S_WR_REQ) && !bus.wr_busy_i && !abort_pend;
    assign bus.rd_addr_o  = src_q;
    assign bus.wr_addr_o  = dst_q;
    assign bus.wr_wdata_o = wdata_q;

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign aborted_o    = aborted_q;
    assign irq_o        = irq_q;
    assign words_left_o = count_q;

endmodule

// File: tb/tb_ndma_xfer_ctrl.sv
// Randomised bench for ndma_xfer_ctrl: the bench plays both managers and predicts
// each transfer's address sequence, data, word count and outcome from the transfer rules.
module tb_ndma_xfer_ctrl;

    localparam int unsigned STRIDE = 4;
    localparam int          BUDGET = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, abort_i, src_inc_i, dst_inc_i, irq_clr_i;
    logic [31:0] src_addr_i, dst_addr_i;
    logic [15:0] len_i;
    logic        busy_o, done_o, aborted_o, irq_o;
    logic [15:0] words_left_o;

    int n_checks = 0;
    int n_fail   = 0;

    ndma_xfer_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ndma_xfer_ctrl #(.ADDR_W(32), .DATA_W(32), .LEN_W(16), .STRIDE(STRIDE)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .src_addr_i   (src_addr_i),
        .dst_addr_i   (dst_addr_i),
        .len_i        (len_i),
        .src_inc_i    (src_inc_i),
        .dst_inc_i    (dst_inc_i),
        .irq_clr_i    (irq_clr_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .aborted_o    (aborted_o),
        .irq_o        (irq_o),
        .words_left_o (words_left_o),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        start_i = 1'b0; abort_i = 1'b0; irq_clr_i = 1'b0;
        bus.rd_busy_i = 1'b0; bus.rd_rvalid_i = 1'b0; bus.rd_rdata_i = '0;
        bus.wr_busy_i = 1'b0; bus.wr_done_i = 1'b0;
    endtask

    // mode: 0 zero-wait managers, 1 random busy/latency, 2 five-cycle busy stall on both sides
    // ab_kind: 0 none, 1 abort in RD_WAIT of word ab_k, 2 abort in WR_WAIT of word ab_k,
    //          3 abort together with start (must be dropped)
    task automatic run_xfer(input string name, input logic [31:0] src, input logic [31:0] dst,
                            input int len, input bit sinc, input bit dinc, input int mode,
                            input int ab_kind, input int ab_k, input bit clr_hold);
        int exp_reads, exp_writes, exp_left, exp_lat;
        bit exp_done, ended, got_done;
        int nrd, nwr, rel, rd_due, wr_due, ab_at, first_rv, viol, end_rel, lat;
        logic [31:0] rdq[$];
        logic [31:0] ea;

        exp_done = 1'b1; exp_reads = len; exp_writes = len; exp_left = 0;
        if (ab_kind == 1) begin
            exp_done = 1'b0; exp_reads = ab_k; exp_writes = ab_k - 1; exp_left = len - ab_k + 1;
        end else if (ab_kind == 2 && ab_k < len) begin
            exp_done = 1'b0; exp_reads = ab_k; exp_writes = ab_k; exp_left = len - ab_k;
        end
        exp_lat = 4 * len + 1 + ((mode == 2) ? 10 : 0);

        @(negedge clk);
        idle_inputs();
        start_i = 1'b1; abort_i = (ab_kind == 3);
        src_addr_i = src; dst_addr_i = dst; len_i = 16'(len);
        src_inc_i = sinc; dst_inc_i = dinc; irq_clr_i = clr_hold;

        nrd = 0; nwr = 0; rd_due = -1; wr_due = -1; ab_at = -1; first_rv = 0;
        viol = 0; end_rel = -1; ended = 1'b0; got_done = 1'b0; rel = 0;
        while (!ended && rel < BUDGET) begin
            rel++;
            @(negedge clk);
            start_i    = ($urandom_range(0, 7) == 0);
            src_addr_i = $urandom; dst_addr_i = $urandom; len_i = 16'($urandom);
            src_inc_i  = 1'($urandom); dst_inc_i = 1'($urandom);
            abort_i    = (rel == ab_at);
            bus.rd_rvalid_i = 1'b0; bus.wr_done_i = 1'b0;
            bus.rd_rdata_i  = $urandom;
            case (mode)
                1: begin
                    bus.rd_busy_i = ($urandom_range(0, 99) < 30);
                    bus.wr_busy_i = ($urandom_range(0, 99) < 30);
                end
                2: begin
                    bus.rd_busy_i = (rel <= 5);
                    bus.wr_busy_i = (first_rv > 0) && (rel > first_rv) && (rel <= first_rv + 5);
                end
                default: begin
                    bus.rd_busy_i = 1'b0; bus.wr_busy_i = 1'b0;
                end
            endcase
            if (rel == rd_due) begin
                bus.rd_rvalid_i = 1'b1;
                rdq.push_back(bus.rd_rdata_i);
                if (first_rv == 0) first_rv = rel;
            end
            if (rel == wr_due) bus.wr_done_i = 1'b1;
            #1;
            if (rel == 1) begin
                check_val({name, ":busy_after_start"}, 64'(busy_o), 64'd1);
                check_val({name, ":words_left_start"}, 64'(words_left_o), 64'(len));
            end
            lat = (mode == 1) ? int'($urandom_range(0, 3)) : 0;
            if (bus.rd_req_o) begin
                if (bus.rd_busy_i) viol++;
                ea = src + (sinc ? 32'(nrd * STRIDE) : 32'd0);
                check_val({name, ":rd_addr"}, 64'(bus.rd_addr_o), 64'(ea));
                nrd++;
                rd_due = rel + 1 + lat;
                if (ab_kind == 1 && nrd == ab_k) ab_at = rel + 1;
            end
            if (bus.wr_req_o) begin
                if (bus.wr_busy_i) viol++;
                ea = dst + (dinc ? 32'(nwr * STRIDE) : 32'd0);
                check_val({name, ":wr_addr"}, 64'(bus.wr_addr_o), 64'(ea));
                if (rdq.size() > nwr)
                    check_val({name, ":wr_data"}, 64'(bus.wr_wdata_o), 64'(rdq[nwr]));
                else
                    check_val({name, ":wr_before_read"}, 64'(nwr), 64'(rdq.size()));
                nwr++;
                wr_due = rel + 1 + lat;
                if (ab_kind == 2 && nwr == ab_k) ab_at = rel + 1;
            end
            if (done_o || aborted_o) begin
                ended = 1'b1; got_done = done_o; end_rel = rel;
                check_val({name, ":irq_at_end"}, 64'(irq_o), 64'd1);
                check_val({name, ":words_left_end"}, 64'(words_left_o), 64'(exp_left));
                check_val({name, ":single_end_pulse"}, 64'(done_o & aborted_o), 64'd0);
            end
        end
        check_val({name, ":completed_in_budget"}, 64'(ended), 64'd1);
        check_val({name, ":done_not_abort"}, 64'(got_done), 64'(exp_done));
        check_val({name, ":n_reads"}, 64'(nrd), 64'(exp_reads));
        check_val({name, ":n_writes"}, 64'(nwr), 64'(exp_writes));
        check_val({name, ":strobe_while_busy"}, 64'(viol), 64'd0);
        if (mode != 1 && ab_kind != 1 && ab_kind != 2)
            check_val({name, ":latency"}, 64'(end_rel), 64'(exp_lat));

        @(negedge clk);
        idle_inputs();
        #1;
        check_val({name, ":idle_after_end"}, 64'({busy_o, done_o, aborted_o}), 64'd0);
        check_val({name, ":irq_sticky"}, 64'(irq_o), 64'(!clr_hold));
        @(negedge clk);
        irq_clr_i = 1'b1;
        @(negedge clk);
        irq_clr_i = 1'b0;
        #1;
        check_val({name, ":irq_cleared"}, 64'(irq_o), 64'd0);
    endtask

    task automatic reset_mid_transfer();
        int pulses;
        @(negedge clk);
        idle_inputs();
        start_i = 1'b1; src_addr_i = 32'h4000; dst_addr_i = 32'h8000; len_i = 16'd8;
        src_inc_i = 1'b1; dst_inc_i = 1'b1;
        bus.rd_rvalid_i = 1'b1; bus.rd_rdata_i = 32'hDEAD_BEEF; bus.wr_done_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        #1;
        check_val("rst_mid:busy_before", 64'(busy_o), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid:status_zero",
                  64'({busy_o, done_o, aborted_o, irq_o, words_left_o}), 64'd0);
        check_val("rst_mid:bus_zero",
                  64'(|{bus.rd_req_o, bus.wr_req_o, bus.rd_addr_o, bus.wr_addr_o, bus.wr_wdata_o}),
                  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (done_o || aborted_o || busy_o) pulses++;
        end
        check_val("rst_mid:no_pulse_after", 64'(pulses), 64'd0);
        idle_inputs();
    endtask

    initial begin
        int len, kind, k;
        rst_n = 1'b0;
        src_addr_i = '0; dst_addr_i = '0; len_i = '0; src_inc_i = 1'b0; dst_inc_i = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        check_val("reset:status",
                  64'({busy_o, done_o, aborted_o, irq_o, words_left_o}), 64'd0);
        check_val("reset:bus",
                  64'(|{bus.rd_req_o, bus.wr_req_o, bus.rd_addr_o, bus.wr_addr_o, bus.wr_wdata_o}),
                  64'd0);
        rst_n = 1'b1;

        run_xfer("basic3",    32'h100, 32'h200, 3, 1'b1, 1'b1, 0, 0, 0, 1'b0);
        run_xfer("empty",     32'h100, 32'h200, 0, 1'b1, 1'b1, 0, 0, 0, 1'b0);
        run_xfer("fixed_src", 32'h300, 32'h500, 4, 1'b0, 1'b1, 0, 0, 0, 1'b0);
        run_xfer("abort_rd3", 32'h100, 32'h900, 8, 1'b1, 1'b1, 0, 1, 3, 1'b0);
        run_xfer("stall",     32'h600, 32'h700, 3, 1'b1, 1'b1, 2, 0, 0, 1'b0);
        run_xfer("wrap",      32'hFFFF_FFFC, 32'hFFFF_FFF8, 2, 1'b1, 1'b1, 0, 0, 0, 1'b0);
        run_xfer("set_wins",  32'h10, 32'h20, 2, 1'b1, 1'b0, 0, 0, 0, 1'b1);
        run_xfer("abort_last",32'h40, 32'h80, 3, 1'b1, 1'b1, 0, 2, 3, 1'b0);
        run_xfer("abort_wr2", 32'h40, 32'h80, 5, 1'b1, 1'b1, 0, 2, 2, 1'b0);
        run_xfer("start_abt", 32'h44, 32'h88, 2, 1'b1, 1'b1, 0, 3, 0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            len  = int'($urandom_range(0, 6));
            kind = (len == 0) ? 0 : int'($urandom_range(0, 3));
            k    = (len == 0) ? 0 : int'($urandom_range(1, len));
            run_xfer("random", $urandom, $urandom, len, 1'($urandom), 1'($urandom),
                     1, kind, k, 1'($urandom));
        end

        reset_mid_transfer();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
